// File: rtl/eth_tx_framer.sv
// Gigabit Ethernet transmit framer: adds preamble/SFD, pads short frames, appends
// the IEEE 802.3 CRC-32 FCS and enforces the inter-frame gap on a GMII TX port.
module eth_tx_framer #(
  parameter int unsigned MIN_LEN    = 60,
  parameter bit          PAD_EN     = 1'b1,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic [7:0] gmii_txd_o,
  output logic       gmii_tx_en_o,
  output logic       gmii_tx_er_o,
  output logic       tx_busy_o,
  output logic       frame_done_o,
  output logic       tx_underrun_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAD  = 3'd3,
    ST_FCS  = 3'd4,
    ST_IFG  = 3'd5,
    ST_DROP = 3'd6
  } state_e;

  localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
  // The IDLE cycle and the first PRE cycle also keep tx_en low, so the IFG state
  // itself is shortened to make the visible gap exactly IFG_CYCLES long.
  localparam logic [15:0] IFG_LAST_C = (IFG_CYCLES > 2) ? 16'(IFG_CYCLES - 2) : 16'd0;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 32'hEDB88320;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_e      state_q;
  logic [2:0]  pre_cnt_q;
  logic [1:0]  fcs_idx_q;
  logic [15:0] byte_cnt_q;
  logic [15:0] ifg_cnt_q;
  logic [31:0] crc_q;
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        tx_er_q;
  logic        frame_done_q;
  logic        underrun_q;

  logic [7:0]  crc_byte_d;
  logic [31:0] crc_d;
  logic [15:0] byte_cnt_d;
  logic [7:0]  fcs_byte_d;
  logic [31:0] fcs_d;

  // Next CRC, saturating byte count and the FCS byte selected for this cycle.
  always_comb begin
    crc_byte_d = 8'h00;
    if (state_q == ST_PAD) begin
      crc_byte_d = 8'h00;
    end else begin
      crc_byte_d = s_data_i;
    end
    crc_d = crc32_byte(crc_q, crc_byte_d);

    byte_cnt_d = byte_cnt_q;
    if (byte_cnt_q == 16'hFFFF) begin
      byte_cnt_d = byte_cnt_q;
    end else begin
      byte_cnt_d = byte_cnt_q + 16'd1;
    end

    fcs_d      = ~crc_q;
    fcs_byte_d = 8'h00;
    case (fcs_idx_q)
      2'd0:    fcs_byte_d = fcs_d[7:0];
      2'd1:    fcs_byte_d = fcs_d[15:8];
      2'd2:    fcs_byte_d = fcs_d[23:16];
      2'd3:    fcs_byte_d = fcs_d[31:24];
      default: fcs_byte_d = 8'h00;
    endcase
  end

  // Framing FSM with registered GMII outputs and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= 3'd0;
      fcs_idx_q    <= 2'd0;
      byte_cnt_q   <= 16'd0;
      ifg_cnt_q    <= 16'd0;
      crc_q        <= 32'hFFFFFFFF;
      txd_q        <= 8'h00;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      txd_q        <= 8'h00;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          crc_q      <= 32'hFFFFFFFF;
          byte_cnt_q <= 16'd0;
          pre_cnt_q  <= 3'd0;
          fcs_idx_q  <= 2'd0;
          if (s_valid_i) begin
            state_q <= ST_PRE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_PRE: begin
          tx_en_q   <= 1'b1;
          pre_cnt_q <= pre_cnt_q + 3'd1;
          if (pre_cnt_q == 3'd7) begin
            txd_q   <= 8'hD5;
            state_q <= ST_DATA;
          end else begin
            txd_q   <= 8'h55;
          end
        end
        ST_DATA: begin
          tx_en_q <= 1'b1;
          if (s_valid_i) begin
            txd_q      <= s_data_i;
            crc_q      <= crc_d;
            byte_cnt_q <= byte_cnt_d;
            if (s_last_i) begin
              if (PAD_EN && (byte_cnt_d < MIN_LEN_C)) begin
                state_q <= ST_PAD;
              end else begin
                state_q <= ST_FCS;
              end
            end else begin
              state_q <= ST_DATA;
            end
          end else begin
            // Source starved mid-frame: poison the frame on the wire and abort.
            txd_q      <= 8'h00;
            tx_er_q    <= 1'b1;
            underrun_q <= 1'b1;
            state_q    <= ST_DROP;
          end
        end
        ST_PAD: begin
          tx_en_q    <= 1'b1;
          txd_q      <= 8'h00;
          crc_q      <= crc_d;
          byte_cnt_q <= byte_cnt_d;
          if (byte_cnt_d >= MIN_LEN_C) begin
            state_q <= ST_FCS;
          end else begin
            state_q <= ST_PAD;
          end
        end
        ST_FCS: begin
          tx_en_q   <= 1'b1;
          txd_q     <= fcs_byte_d;
          fcs_idx_q <= fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            frame_done_q <= 1'b1;
            ifg_cnt_q    <= 16'd0;
            state_q      <= ST_IFG;
          end else begin
            state_q <= ST_FCS;
          end
        end
        ST_IFG: begin
          if (ifg_cnt_q >= IFG_LAST_C) begin
            state_q <= ST_IDLE;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + 16'd1;
          end
        end
        ST_DROP: begin
          if (s_valid_i && s_last_i) begin
            ifg_cnt_q <= 16'd0;
            state_q   <= ST_IFG;
          end else begin
            state_q <= ST_DROP;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready_o     = (state_q == ST_DATA) || (state_q == ST_DROP);
  assign tx_busy_o     = (state_q != ST_IDLE);
  assign gmii_txd_o    = txd_q;
  assign gmii_tx_en_o  = tx_en_q;
  assign gmii_tx_er_o  = tx_er_q;
  assign frame_done_o  = frame_done_q;
  assign tx_underrun_o = underrun_q;

endmodule
